// File: rtl/rtc_bcd_writer.sv
// Write side of the RTC time/date path: range-checks one 2-digit BCD field and
// drives a single multiplexed address/data write cycle on the external RTC bus.
module rtc_bcd_writer #(
  parameter int unsigned T_WR  = 4,
  parameter int unsigned T_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic [2:0] Cod,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       AD_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FAIL  = 3'd2,
    A_WR  = 3'd3,
    A_GAP = 3'd4,
    D_WR  = 3'd5,
    D_GAP = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic [7:0] WR_LOAD  = 8'(T_WR - 1);
  localparam logic [7:0] GAP_LOAD = 8'(T_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cod_q, cod_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       cs_n_q, cs_n_d, wr_n_q, wr_n_d, ad_n_q, ad_n_d, ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic [7:0] max_bcd;
  logic       field_ok;

  // Upper limit of each field type, the same value the BCD counters wrap at.
  always_comb begin
    max_bcd = 8'h59;
    case (cod_q)
      3'b000: max_bcd = 8'h01;
      3'b001: max_bcd = 8'h12;
      3'b010: max_bcd = 8'h23;
      3'b011: max_bcd = 8'h59;
      3'b100: max_bcd = 8'h31;
      3'b101: max_bcd = 8'h12;
      3'b110: max_bcd = 8'h99;
      3'b111: max_bcd = 8'h59;
      default: max_bcd = 8'h59;
    endcase
  end

  // With both digits <= 9, a plain binary compare orders BCD values correctly.
  assign field_ok = (data_q[7:4] <= 4'd9) && (data_q[3:0] <= 4'd9) && (data_q <= max_bcd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cod_d   = cod_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = addr;
        data_d  = {BCD1, BCD0};
        cod_d   = Cod;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = field_ok ? A_WR : FAIL;
        cnt_d   = WR_LOAD;
      end
      FAIL: state_d = IDLE;
      A_WR: if (cnt_q == 8'd0) begin
        state_d = A_GAP;
        cnt_d   = GAP_LOAD;
      end else cnt_d = cnt_q - 8'd1;
      A_GAP: if (cnt_q == 8'd0) begin
        state_d = D_WR;
        cnt_d   = WR_LOAD;
      end else cnt_d = cnt_q - 8'd1;
      D_WR: if (cnt_q == 8'd0) begin
        state_d = D_GAP;
        cnt_d   = GAP_LOAD;
      end else cnt_d = cnt_q - 8'd1;
      D_GAP: if (cnt_q == 8'd0) state_d = DONE;
      else cnt_d = cnt_q - 8'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = 1'b0;
    err_d    = 1'b0;
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    case (state_d)
      FAIL: err_d = 1'b1;
      A_WR, A_GAP: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q;
        wr_n_d   = (state_d == A_GAP);
      end
      D_WR, D_GAP: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = data_q;
        wr_n_d   = (state_d == D_GAP);
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      cod_q    <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cod_q    <= cod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      ad_n_q   <= ad_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign CS_n      = cs_n_q;
  assign RD_n      = 1'b1;
  assign WR_n      = wr_n_q;
  assign AD_n      = ad_n_q;
  assign ad_oe     = ad_oe_q;
  assign ad_out    = ad_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bcd_writer.sv
// Directed bench for rtc_bcd_writer: default-timing instance plus a T_WR=T_GAP=1
// instance, checked cycle by cycle against a positional model of the bus cycle.
module tb_rtc_bcd_writer;

  typedef struct packed {
    logic       busy, done, err, cs_n, rd_n, wr_n, ad_n, ad_oe;
    logic [7:0] ad_out;
  } obs_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b1, b0;
    logic [2:0] cod;
    bit         ok;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [7:0] addr;
  logic [3:0] bcd1, bcd0;
  logic [2:0] cod;
  obs_t       obs_a, obs_b, mon;
  logic [2:0] dbg_a, dbg_b;
  bit         sel;
  logic [7:0] last_ad [2];
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  rtc_bcd_writer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr), .BCD1(bcd1), .BCD0(bcd0), .Cod(cod),
    .busy(obs_a.busy), .done(obs_a.done), .err(obs_a.err), .CS_n(obs_a.cs_n), .RD_n(obs_a.rd_n),
    .WR_n(obs_a.wr_n), .AD_n(obs_a.ad_n), .ad_out(obs_a.ad_out), .ad_oe(obs_a.ad_oe),
    .dbg_state(dbg_a)
  );

  rtc_bcd_writer #(.T_WR(1), .T_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr), .BCD1(bcd1), .BCD0(bcd0), .Cod(cod),
    .busy(obs_b.busy), .done(obs_b.done), .err(obs_b.err), .CS_n(obs_b.cs_n), .RD_n(obs_b.rd_n),
    .WR_n(obs_b.wr_n), .AD_n(obs_b.ad_n), .ad_out(obs_b.ad_out), .ad_oe(obs_b.ad_oe),
    .dbg_state(dbg_b)
  );

  always_comb mon = sel ? obs_b : obs_a;

  // Expected pins k cycles after the capturing edge (k=1 is the first busy cycle).
  function automatic obs_t exp_obs(int k, int tw, int tg, bit ok,
                                   logic [7:0] a, logic [7:0] d, logic [7:0] prev);
    obs_t o;
    int   n;
    n = 2 + 2 * (tw + tg);
    o.busy = 1'b0; o.done = 1'b0; o.err = 1'b0; o.cs_n = 1'b1; o.rd_n = 1'b1;
    o.wr_n = 1'b1; o.ad_n = 1'b1; o.ad_oe = 1'b0; o.ad_out = prev;
    if (!ok) begin
      if (k == 1) o.busy = 1'b1;
      else if (k == 2) begin o.busy = 1'b1; o.err = 1'b1; end
    end else begin
      if (k >= 1 && k <= n) o.busy = 1'b1;
      if (k >= 2 && k <= 1 + tw + tg) begin
        o.cs_n = 1'b0; o.ad_n = 1'b0; o.ad_oe = 1'b1; o.ad_out = a;
        o.wr_n = (k <= 1 + tw) ? 1'b0 : 1'b1;
      end else if (k >= 2 + tw + tg && k <= 1 + 2 * (tw + tg)) begin
        o.cs_n = 1'b0; o.ad_oe = 1'b1; o.ad_out = d;
        o.wr_n = (k <= 1 + 2 * tw + tg) ? 1'b0 : 1'b1;
      end else if (k >= n) o.ad_out = d;
      if (k == n) o.done = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else start_a = v;
  endtask

  // mode 0: plain write; 1: second start pulse with other data at clk 5;
  // 2: start raised so it is sampled on the edge that returns to IDLE.
  task automatic run_txn(input bit s, input string tag, input logic [7:0] a,
                         input logic [3:0] b1, input logic [3:0] b0, input logic [2:0] c,
                         input bit ok, input int mode);
    int   tw, tg, n_len;
    obs_t e;
    sel = s;
    tw = s ? 1 : 4;
    tg = s ? 1 : 2;
    n_len = ok ? 2 + 2 * (tw + tg) : 2;
    addr = a; bcd1 = b1; bcd0 = b0; cod = c;
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    for (int k = 1; k <= n_len + 1; k++) begin
      if (k > 1) begin
        @(negedge clk);
        set_start(s, 1'b0);
      end
      e = exp_obs(k, tw, tg, ok, a, {b1, b0}, last_ad[s]);
      check($sformatf("%s k=%0d", tag, k), mon, e);
      if (mode == 1 && k == 4) begin
        set_start(s, 1'b1);
        addr = a ^ 8'hFF; bcd1 = 4'd1; bcd0 = 4'd1; cod = 3'b110;
      end
      if (mode == 2 && k == n_len) set_start(s, 1'b1);
    end
    if (ok) last_ad[s] = {b1, b0};
  endtask

  vec_t vecs [16];
  obs_t rst_obs;

  initial begin
    vecs[0]  = '{a: 8'h21, b1: 4'd5, b0: 4'd9,  cod: 3'b011, ok: 1'b1};
    vecs[1]  = '{a: 8'h22, b1: 4'd6, b0: 4'd0,  cod: 3'b011, ok: 1'b0};
    vecs[2]  = '{a: 8'h05, b1: 4'd1, b0: 4'd2,  cod: 3'b101, ok: 1'b1};
    vecs[3]  = '{a: 8'h06, b1: 4'd1, b0: 4'd3,  cod: 3'b101, ok: 1'b0};
    vecs[4]  = '{a: 8'h07, b1: 4'd0, b0: 4'd1,  cod: 3'b000, ok: 1'b1};
    vecs[5]  = '{a: 8'h08, b1: 4'd0, b0: 4'd2,  cod: 3'b000, ok: 1'b0};
    vecs[6]  = '{a: 8'h09, b1: 4'd9, b0: 4'd9,  cod: 3'b110, ok: 1'b1};
    vecs[7]  = '{a: 8'h0A, b1: 4'd0, b0: 4'hA,  cod: 3'b110, ok: 1'b0};
    vecs[8]  = '{a: 8'h0B, b1: 4'd0, b0: 4'hA,  cod: 3'b111, ok: 1'b0};
    vecs[9]  = '{a: 8'h0C, b1: 4'd2, b0: 4'd3,  cod: 3'b010, ok: 1'b1};
    vecs[10] = '{a: 8'h0D, b1: 4'd2, b0: 4'd4,  cod: 3'b010, ok: 1'b0};
    vecs[11] = '{a: 8'h0E, b1: 4'd3, b0: 4'd1,  cod: 3'b100, ok: 1'b1};
    vecs[12] = '{a: 8'h0F, b1: 4'd3, b0: 4'd2,  cod: 3'b100, ok: 1'b0};
    vecs[13] = '{a: 8'hA5, b1: 4'd5, b0: 4'd9,  cod: 3'b111, ok: 1'b1};
    vecs[14] = '{a: 8'h3C, b1: 4'hA, b0: 4'd0,  cod: 3'b110, ok: 1'b0};
    vecs[15] = '{a: 8'h44, b1: 4'd1, b0: 4'd2,  cod: 3'b001, ok: 1'b1};

    rst_obs = '{busy: 1'b0, done: 1'b0, err: 1'b0, cs_n: 1'b1, rd_n: 1'b1,
                wr_n: 1'b1, ad_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00};
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    addr = 8'h00; bcd1 = 4'd0; bcd0 = 4'd0; cod = 3'b000; sel = 1'b0;
    last_ad[0] = 8'h00; last_ad[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_a", obs_a, rst_obs);
    check("reset_b", obs_b, rst_obs);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_txn(1'b0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].b1, vecs[i].b0,
              vecs[i].cod, vecs[i].ok, 0);

    run_txn(1'b0, "drop_start", 8'h21, 4'd5, 4'd9, 3'b011, 1'b1, 1);
    run_txn(1'b0, "start_at_done", 8'h31, 4'd4, 4'd7, 3'b011, 1'b1, 2);
    run_txn(1'b0, "after_done", 8'h32, 4'd0, 4'd9, 3'b001, 1'b1, 0);

    run_txn(1'b1, "fast1", 8'h21, 4'd5, 4'd9, 3'b011, 1'b1, 0);
    run_txn(1'b1, "fast2", 8'h52, 4'd2, 4'd3, 3'b010, 1'b1, 0);
    run_txn(1'b1, "fast_bad", 8'h53, 4'd2, 4'd4, 3'b010, 1'b0, 0);
    run_txn(1'b1, "fast3", 8'h54, 4'd3, 4'd1, 3'b100, 1'b1, 0);

    // Reset asserted in the middle of the data strobe.
    sel = 1'b0;
    addr = 8'h33; bcd1 = 4'd4; bcd0 = 4'd5; cod = 3'b011;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_dwr", obs_a, exp_obs(9, 4, 2, 1'b1, 8'h33, 8'h45, last_ad[0]));
    reset = 1'b1;
    #1;
    check("mid_reset", obs_a, rst_obs);
    @(negedge clk);
    reset = 1'b0;
    last_ad[0] = 8'h00; last_ad[1] = 8'h00;
    @(negedge clk);
    run_txn(1'b0, "post_reset", 8'h21, 4'd5, 4'd9, 3'b011, 1'b1, 0);
    run_txn(1'b1, "post_reset_b", 8'h12, 4'd0, 4'd1, 3'b000, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
